// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fills the IF/ID register from the
// combinational instruction memory, and applies start/halt/stall/redirect control.
module fetch_ctrl #(
    parameter int                PC_W     = 14,
    parameter int                IW       = 32,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter logic [IW-1:0]     NOP_WORD = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            halt,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_target,
    output logic [PC_W-1:0] pc_out,
    input  logic [IW-1:0]   ir_in,
    output logic [IW-1:0]   if_id_ir,
    output logic [PC_W-1:0] if_id_pc,
    output logic            if_id_valid,
    output logic            running,
    output logic [31:0]     fetch_cnt,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [IW-1:0]   r_ir;
    logic [IW-1:0]   w_ir_nxt;
    logic [PC_W-1:0] r_ipc;
    logic [PC_W-1:0] w_ipc_nxt;
    logic            r_valid;
    logic            w_valid_nxt;
    logic [31:0]     r_cnt;
    logic [31:0]     w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= NOP_WORD;
            r_ipc   <= '0;
            r_valid <= 1'b0;
            r_cnt   <= 32'd0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_ipc   <= w_ipc_nxt;
            r_valid <= w_valid_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // In RUN exactly one action per edge: halt > redirect > stall > advance.
    always_comb begin
        w_next_state = r_state;
        w_pc_nxt     = r_pc;
        w_ir_nxt     = r_ir;
        w_ipc_nxt    = r_ipc;
        w_valid_nxt  = r_valid;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (redirect_valid) w_pc_nxt = redirect_target;
                if (start)          w_next_state = S_RUN;
            end
            S_RUN: begin
                if (halt) begin
                    w_next_state = S_HALTED;
                    w_ir_nxt     = NOP_WORD;
                    w_valid_nxt  = 1'b0;
                end else if (redirect_valid) begin
                    // The word on ir_in is wrong-path; replace it with a bubble.
                    w_pc_nxt    = redirect_target;
                    w_ir_nxt    = NOP_WORD;
                    w_valid_nxt = 1'b0;
                end else if (!stall) begin
                    w_ir_nxt    = ir_in;
                    w_ipc_nxt   = r_pc;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = r_pc + PC_W'(1);
                    w_cnt_nxt   = r_cnt + 32'd1;
                end
            end
            S_HALTED: begin
                if (redirect_valid)   w_pc_nxt = redirect_target;
                if (start && !halt)   w_next_state = S_RUN;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign pc_out      = r_pc;
    assign if_id_ir    = r_ir;
    assign if_id_pc    = r_ipc;
    assign if_id_valid = r_valid;
    assign fetch_cnt   = r_cnt;
    assign running     = (r_state == S_RUN);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed scenarios then random control traffic,
// checked against a behavioural fetch model.
module tb_fetch_ctrl;
  localparam int PC_W = 14;
  localparam int IW = 32;
  localparam int DEPTH = 1 << PC_W;
  localparam logic [PC_W-1:0] RESET_PC = '0;
  localparam logic [IW-1:0] NOP_WORD = 32'h0000_0013;

  logic clk;
  logic reset, start, halt, stall, redirect_valid;
  logic [PC_W-1:0] redirect_target;
  logic [PC_W-1:0] pc_out;
  logic [IW-1:0] ir_in;
  logic [IW-1:0] if_id_ir;
  logic [PC_W-1:0] if_id_pc;
  logic if_id_valid, running;
  logic [31:0] fetch_cnt;
  logic [1:0] dbg_state;

  logic [IW-1:0] mem [DEPTH];

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic valid;
    logic run;
    logic [IW-1:0] ir;
    logic [PC_W-1:0] ipc;
    logic [31:0] cnt;
  } stat_t;

  logic [PC_W+IW-1:0] exp_q[$];
  stat_t stat_q[$];

  int n_checks = 0;
  int n_err = 0;

  // behavioural model: mode 0 idle, 1 run, 2 halted
  int m_mode;
  int m_pc;
  logic [IW-1:0] m_ir;
  int m_ipc;
  logic m_valid;
  logic [31:0] m_cnt;

  fetch_ctrl #(
    .PC_W(PC_W), .IW(IW), .RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .pc_out(pc_out), .ir_in(ir_in), .if_id_ir(if_id_ir), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .running(running), .fetch_cnt(fetch_cnt),
    .dbg_state(dbg_state)
  );

  assign ir_in = mem[pc_out];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc = int'(RESET_PC);
    m_ir = NOP_WORD;
    m_ipc = 0;
    m_valid = 1'b0;
    m_cnt = 32'd0;
  endtask

  // driver: set inputs for the next edge and record what that edge must produce
  task automatic cyc(input bit rs, input bit st, input bit ha, input bit sl,
                     input bit rv, input int rt);
    stat_t s;
    @(negedge clk);
    reset = rs; start = st; halt = ha; stall = sl;
    redirect_valid = rv; redirect_target = PC_W'(rt);
    if (rs) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (rv) m_pc = rt;
      if (st) m_mode = 1;
    end else if (m_mode == 1) begin
      if (ha) begin
        m_mode = 2; m_ir = NOP_WORD; m_valid = 1'b0;
      end else if (rv) begin
        m_pc = rt; m_ir = NOP_WORD; m_valid = 1'b0;
      end else if (!sl) begin
        m_ir = mem[m_pc];
        m_ipc = m_pc;
        m_valid = 1'b1;
        exp_q.push_back({PC_W'(m_pc), mem[m_pc]});
        m_pc = (m_pc + 1) % DEPTH;
        m_cnt = m_cnt + 1;
      end
    end else begin
      if (rv) m_pc = rt;
      if (st && !ha) m_mode = 1;
    end
    s.pc = PC_W'(m_pc);
    s.valid = m_valid;
    s.run = (m_mode == 1);
    s.ir = m_ir;
    s.ipc = PC_W'(m_ipc);
    s.cnt = m_cnt;
    stat_q.push_back(s);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // monitor: per-edge status plus delivery scoreboard
  initial begin
    stat_t s;
    logic [PC_W+IW-1:0] e;
    logic [31:0] prev_cnt;
    prev_cnt = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        check("pc_out", 64'(pc_out), 64'(s.pc));
        check("if_id_valid", 64'(if_id_valid), 64'(s.valid));
        check("running", 64'(running), 64'(s.run));
        check("if_id_ir", 64'(if_id_ir), 64'(s.ir));
        check("if_id_pc", 64'(if_id_pc), 64'(s.ipc));
        check("fetch_cnt", 64'(fetch_cnt), 64'(s.cnt));
      end
      if (if_id_valid && fetch_cnt != prev_cnt) begin
        if (exp_q.size() == 0) begin
          check("unexpected_delivery", 64'(if_id_pc), 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("deliver_pc", 64'(if_id_pc), 64'(e[PC_W+IW-1:IW]));
          check("deliver_ir", 64'(if_id_ir), 64'(e[IW-1:0]));
        end
      end
      prev_cnt = fetch_cnt;
    end
  end

  // stimulus
  initial begin
    bit st, ha, sl, rv, rs;
    int rt;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h100 + i;
    reset = 1'b1; start = 1'b0; halt = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    model_reset();

    // reset then start; three fetches
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle_n(1);
    cyc(0, 1, 0, 0, 0, 0);
    idle_n(5);                         // pc_out now 5
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
    idle_n(5);                         // pc_out now 10
    cyc(0, 0, 0, 1, 1, 40);            // redirect beats stall
    idle_n(3);
    cyc(0, 0, 0, 0, 1, 18);
    idle_n(2);                         // pc_out now 20
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 7);
    cyc(0, 1, 1, 0, 0, 0);             // start with halt stays halted
    cyc(0, 1, 0, 0, 0, 0);
    idle_n(3);

    // wrap-around from a preset PC
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 16382);
    cyc(0, 1, 0, 0, 0, 0);
    idle_n(5);

    // reset mid-run with stall held and fetch_cnt at 12
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    idle_n(12);
    cyc(1, 0, 0, 1, 0, 0);
    idle_n(2);

    // random control traffic
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 79) == 0);
      ha = ($urandom_range(0, 11) == 0);
      sl = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 7) == 0);
      st = rv ? 1'b0 : ($urandom_range(0, 4) == 0);
      rt = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 4, DEPTH - 1)
                                       : $urandom_range(0, DEPTH - 1);
      cyc(rs, st, ha, sl, rv, rt);
    end

    idle_n(2);
    @(posedge clk);
    #2;
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("stat_q_drained", 64'(stat_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the RISC CPU pipeline. It owns the program counter that addresses the 16K-word instruction memory. It captures the returned 32-bit instruction word into the IF/ID pipeline register, and applies start, halt, stall and redirect control from the rest of the core. On a redirect it squashes the wrong-path word by injecting a NOP bubble, so the program image no longer needs hand-placed NOP padding after jumps.

## Interface
Parameters:
- PC_W, 14, program-counter and instruction-memory address width
- IW, 32, instruction word width
- RESET_PC, 14'd0, PC value loaded at reset
- NOP_WORD, 32'd0, encoding injected into IF/ID on bubbles and at reset

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  level; moves IDLE or HALTED to RUN
- halt  in  1  level; moves RUN to HALTED
- stall  in  1  hazard-unit hold of PC and IF/ID
- redirect_valid  in  1  jump/branch taken in execute
- redirect_target  in  PC_W  new PC (absolute, already resolved)
- pc_out  out  PC_W  address to instruction memory (equals pc_q)
- ir_in  in  IW  instruction word from memory, combinational on pc_out
- if_id_ir  out  IW  registered instruction to decode
- if_id_pc  out  PC_W  PC of if_id_ir
- if_id_valid  out  1  if_id_ir is a real fetched instruction
- running  out  1  state == RUN
- fetch_cnt  out  32  count of valid instructions delivered

## Operation
- FSM states: IDLE, RUN, HALTED. Reset state is IDLE.
- **IDLE**
  - pc_q holds. if_id_valid=0, if_id_ir=NOP_WORD.
  - start=1: go to RUN. PC does not advance on this edge.
  - redirect_valid=1: load pc_q from redirect_target, stay in IDLE. This is the PC preset path.
- **RUN**, one action per edge, priority halt > redirect > stall > advance:
  - halt: go to HALTED. pc_q holds. if_id_ir←NOP_WORD, if_id_valid←0.
  - redirect: pc_q←redirect_target. if_id_ir←NOP_WORD, if_id_valid←0, if_id_pc holds. The word currently on ir_in is discarded.
  - stall: pc_q, if_id_ir, if_id_pc, if_id_valid and fetch_cnt all hold.
  - advance: if_id_ir←ir_in, if_id_pc←pc_q, if_id_valid←1, pc_q←pc_q+1, fetch_cnt←fetch_cnt+1.
- **HALTED**
  - pc_q frozen, if_id_valid=0.
  - start=1 and halt=0: go to RUN. Fetch resumes at pc_q.
  - redirect_valid=1: load pc_q, stay in HALTED.
  - start and halt together: stay HALTED.
- Arithmetic:
  - pc_q+1 is modulo 2^PC_W: 16383 wraps to 0 with no flag.
  - redirect_target is used as-is; no bounds check.
  - fetch_cnt wraps modulo 2^32.
- Reset mid-operation: the next edge forces IDLE, pc_q=RESET_PC, if_id_ir=NOP_WORD, if_id_pc=0, if_id_valid=0, fetch_cnt=0. Any pending redirect, stall or halt is dropped.

## Timing
- Reset values:
  - pc_out=RESET_PC, if_id_ir=NOP_WORD, if_id_pc=0, if_id_valid=0.
  - running=0, fetch_cnt=0.
- pc_out is a register output. The instruction memory read is combinational, so ir_in is sampled on the same edge that advances the PC.
- Fetch latency: the word at address A appears on if_id_ir one edge after pc_out=A in RUN without stall.
- Throughput: one instruction per cycle in RUN.
- Redirect penalty:
  - The edge that samples redirect_valid produces one bubble.
  - The target word reaches if_id_ir on the following edge.
  - The redirect source is responsible for squashing any younger in-flight stages.
- running is registered and reflects the current state. It rises the cycle after start is sampled.
- stall is honoured in the same cycle it is sampled. No skid or buffering.
- redirect plus stall in the same cycle: redirect wins, and the bubble is inserted even though stall is high.

## Test plan
- **Reset/start:** assert reset 2 cycles, then start=1 for 1 cycle, memory preloaded with word[i]=i+0x100.
  - IDLE after reset: pc_out=0, if_id_valid=0.
  - 3 edges into RUN: if_id_ir=0x100, 0x101, 0x102; if_id_pc=0, 1, 2; fetch_cnt=3.
- **Stall:** in RUN at pc_out=5, hold stall=1 for 3 cycles.
  - pc_out stays 5; if_id_ir/if_id_pc/if_id_valid frozen; fetch_cnt unchanged.
  - After release, the next delivered word is 0x105.
- **Redirect with simultaneous stall:** at pc_out=10, pulse redirect_valid=1, redirect_target=40, stall=1.
  - Next edge: if_id_valid=0, if_id_ir=NOP_WORD, pc_out=40.
  - Following edge: if_id_ir=0x128, if_id_pc=40.
- **Wrap-around:** preset pc_q=16382 via redirect in IDLE, then start.
  - Delivered if_id_pc sequence is 16382, 16383, 0, 1 with no gap.
- **Halt/resume:** halt at pc_out=20 for 2 cycles, apply redirect_target=7 while HALTED, then start.
  - running=0 and if_id_valid=0 while HALTED.
  - After resume, the first delivered if_id_pc=7.
- **Reset mid-run:** assert reset while in RUN with fetch_cnt=12 and stall=1.
  - Next edge: state IDLE, pc_out=0, fetch_cnt=0, if_id_valid=0, running=0.
